// File: rtl/rx_eq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_eq_pkg : shared widths, FSM encoding and lane-mask helper        |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package rx_eq_pkg;

    localparam int LANE_IDX_W = 4;
    localparam int COEFF_W    = 6;
    localparam int PRESET_W   = 4;
    localparam int MAX_LANES  = 16;

    typedef logic [1:0] eqState_t;

    localparam eqState_t c_IDLE  = 2'd0;
    localparam eqState_t c_ISSUE = 2'd1;
    localparam eqState_t c_WAIT  = 2'd2;
    localparam eqState_t c_ACK   = 2'd3;

    // Lanes 0..detected-1 are active; a detected count above the lane count clamps.
    function automatic logic [MAX_LANES-1:0] laneMask(input logic [4:0] detected, input int lanes);
        logic [MAX_LANES-1:0] mask;
        int limit;
        limit = (int'(detected) > lanes) ? lanes : int'(detected);
        mask  = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            mask[i] = (i < limit);
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eq_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | eq_rr_picker : combinational round-robin pick after a pointer       |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module eq_rr_picker
    import rx_eq_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic [LANES-1:0]      req,
    input  logic [LANES-1:0]      eligible,
    input  logic [LANE_IDX_W-1:0] pointer,
    output logic                  valid,
    output logic [LANE_IDX_W-1:0] index
);

    logic [LANES-1:0]      w_cand;
    logic [LANE_IDX_W-1:0] w_sel;

    assign w_cand = req & eligible;

    // Search starts one past the pointer so the last-served lane goes to the back.
    always_comb begin
        valid = 1'b0;
        index = '0;
        w_sel = '0;
        for (int k = 1; k <= LANES; k++) begin
            w_sel = LANE_IDX_W'((int'(pointer) + k) % LANES);
            if (!valid && w_cand[w_sel]) begin
                valid = 1'b1;
                index = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_eq_coeff_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_eq_coeff_scheduler : shares one coefficient calculator among    |
// |                         lanes during Recovery.Equalization         |
// | Revision              : 1.0                                        |
// +--------------------------------------------------------------------+
module rx_eq_coeff_scheduler
    import rx_eq_pkg::*;
#(
    parameter int LANES   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [4:0]                  numberOfDetectedLanes,
    input  logic [LANES-1:0]            req,
    input  logic [PRESET_W*LANES-1:0]   reqPreset,
    output logic                        calcStart,
    output logic [LANE_IDX_W-1:0]       calcLane,
    output logic [PRESET_W-1:0]         calcPreset,
    input  logic                        calcDone,
    input  logic [COEFF_W-1:0]          calcCursor,
    input  logic [COEFF_W-1:0]          calcPre,
    input  logic [COEFF_W-1:0]          calcPost,
    output logic [LANES-1:0]            ack,
    output logic [COEFF_W*LANES-1:0]    CursorCoff,
    output logic [COEFF_W*LANES-1:0]    PreCursorCoff,
    output logic [COEFF_W*LANES-1:0]    PostCursorCoff,
    output logic                        busy,
    output logic                        allDone,
    output logic                        timeoutErr
);

    localparam int c_CNT_W = $clog2(TIMEOUT) + 1;

    eqState_t              r_state;
    logic [LANE_IDX_W-1:0] r_pointer;
    logic [LANE_IDX_W-1:0] r_lane;
    logic [PRESET_W-1:0]   r_preset;
    logic [c_CNT_W-1:0]    r_waitCnt;
    logic                  r_timeoutErr;
    logic [LANES-1:0]      r_ackPrev;
    logic [LANES-1:0]      r_doneVec;

    logic [MAX_LANES-1:0]  w_maskFull;
    logic [LANES-1:0]      w_activeMask;
    logic [LANES-1:0]      w_eligible;
    logic                  w_pickValid;
    logic [LANE_IDX_W-1:0] w_pickIdx;
    logic                  w_write;
    logic [PRESET_W-1:0]   w_presetArr [LANES];

    assign w_maskFull   = laneMask(numberOfDetectedLanes, LANES);
    assign w_activeMask = w_maskFull[LANES-1:0];
    assign w_eligible   = w_activeMask & ~r_ackPrev;

    for (genvar i = 0; i < LANES; i++) begin : g_preset
        assign w_presetArr[i] = reqPreset[i*PRESET_W +: PRESET_W];
    end

    eq_rr_picker #(
        .LANES    (LANES)
    ) u_picker (
        .req      (req),
        .eligible (w_eligible),
        .pointer  (r_pointer),
        .valid    (w_pickValid),
        .index    (w_pickIdx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_pointer    <= LANE_IDX_W'(LANES - 1);
            r_lane       <= '0;
            r_preset     <= '0;
            r_waitCnt    <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (enable && w_pickValid) begin
                        r_lane    <= w_pickIdx;
                        r_preset  <= w_presetArr[w_pickIdx];
                        r_pointer <= w_pickIdx;
                        r_state   <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_waitCnt <= '0;
                    r_state   <= c_WAIT;
                end
                c_WAIT: begin
                    if (!enable) begin
                        r_state <= c_IDLE;
                    end else if (calcDone) begin
                        r_state <= c_ACK;
                    end else if (r_waitCnt == c_CNT_W'(TIMEOUT - 1)) begin
                        r_timeoutErr <= 1'b1;
                        r_state      <= c_IDLE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                c_ACK: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // The result is captured straight into the lane slot as WAIT exits, so the
    // coefficient update becomes visible in the same cycle as the ack pulse.
    assign w_write = (r_state == c_WAIT) && enable && calcDone;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [COEFF_W-1:0] r_cursor;
        logic [COEFF_W-1:0] r_pre;
        logic [COEFF_W-1:0] r_post;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cursor <= '0;
                r_pre    <= '0;
                r_post   <= '0;
            end else if (w_write && (r_lane == LANE_IDX_W'(i))) begin
                r_cursor <= calcCursor;
                r_pre    <= calcPre;
                r_post   <= calcPost;
            end
        end

        assign CursorCoff[i*COEFF_W +: COEFF_W]     = r_cursor;
        assign PreCursorCoff[i*COEFF_W +: COEFF_W]  = r_pre;
        assign PostCursorCoff[i*COEFF_W +: COEFF_W] = r_post;
    end

    always_comb begin
        ack = '0;
        if (r_state == c_ACK) begin
            ack[r_lane] = 1'b1;
        end
    end

    // r_ackPrev keeps a just-served lane out of the very next pick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ackPrev <= '0;
            r_doneVec <= '0;
        end else begin
            r_ackPrev <= ack;
            if (!enable) begin
                r_doneVec <= '0;
            end else begin
                r_doneVec <= r_doneVec | ack;
            end
        end
    end

    assign calcStart  = (r_state == c_ISSUE);
    assign calcLane   = r_lane;
    assign calcPreset = r_preset;
    assign busy       = (r_state != c_IDLE);
    assign timeoutErr = r_timeoutErr;
    assign allDone    = enable && (|w_activeMask) && (&(r_doneVec | ~w_activeMask));

endmodule
`default_nettype wire

// File: tb/tb_rx_eq_coeff_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rx_eq_coeff_scheduler : directed bench with ack scoreboard       |
// | Revision                 : 1.0                                     |
// +--------------------------------------------------------------------+
module tb_rx_eq_coeff_scheduler;

    localparam int LANES   = 16;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [4:0]       numberOfDetectedLanes;
    logic [LANES-1:0] req;
    logic [4*LANES-1:0] reqPreset;
    logic             calcStart;
    logic [3:0]       calcLane;
    logic [3:0]       calcPreset;
    logic             calcDone;
    logic [5:0]       calcCursor;
    logic [5:0]       calcPre;
    logic [5:0]       calcPost;
    logic [LANES-1:0] ack;
    logic [6*LANES-1:0] CursorCoff;
    logic [6*LANES-1:0] PreCursorCoff;
    logic [6*LANES-1:0] PostCursorCoff;
    logic             busy;
    logic             allDone;
    logic             timeoutErr;

    always #5 clk = ~clk;

    rx_eq_coeff_scheduler #(
        .LANES                 (LANES),
        .TIMEOUT               (TIMEOUT)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .req                   (req),
        .reqPreset             (reqPreset),
        .calcStart             (calcStart),
        .calcLane              (calcLane),
        .calcPreset            (calcPreset),
        .calcDone              (calcDone),
        .calcCursor            (calcCursor),
        .calcPre               (calcPre),
        .calcPost              (calcPost),
        .ack                   (ack),
        .CursorCoff            (CursorCoff),
        .PreCursorCoff         (PreCursorCoff),
        .PostCursorCoff        (PostCursorCoff),
        .busy                  (busy),
        .allDone               (allDone),
        .timeoutErr            (timeoutErr)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int lane;
        int cur;
        int pre;
        int post;
        int cycle;
    } exp_t;

    exp_t sbq[$];

    // Requester: req = held pattern minus lanes already served.
    logic [LANES-1:0] reqHold;
    logic [LANES-1:0] dropMask;
    logic [LANES-1:0] pend;
    int               keep [LANES];
    int               left [LANES];
    assign req = reqHold & ~dropMask;

    // Calculator responder settings.
    int               respDelay;
    logic [LANES-1:0] muteMask;
    int               respCur  [LANES];
    int               respPre  [LANES];
    int               respPost [LANES];
    int               startCount = 0;
    int               startCyc   = 0;
    int               startLane  = 0;
    int               startPreset = 0;
    int               ackCount   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        dropMask = '0;
        pend     = '0;
        for (int i = 0; i < LANES; i++) left[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < LANES; i++) begin
                if (!reqHold[i]) begin
                    dropMask[i] = 1'b0;
                    pend[i]     = 1'b0;
                end else if (ack[i]) begin
                    if (keep[i] == 0) dropMask[i] = 1'b1;
                    else begin
                        pend[i] = 1'b1;
                        left[i] = keep[i];
                    end
                end else if (pend[i]) begin
                    if (left[i] == 0) begin
                        dropMask[i] = 1'b1;
                        pend[i]     = 1'b0;
                    end else begin
                        left[i] = left[i] - 1;
                    end
                end
            end
        end
    end

    initial begin
        int l;
        calcDone   = 1'b0;
        calcCursor = '0;
        calcPre    = '0;
        calcPost   = '0;
        forever begin
            @(negedge clk);
            if (calcStart) begin
                startCount++;
                startCyc    = cyc;
                startLane   = int'(calcLane);
                startPreset = int'(calcPreset);
                l = int'(calcLane);
                if (!muteMask[l]) begin
                    repeat (respDelay) @(posedge clk);
                    #1;
                    calcDone   = 1'b1;
                    calcCursor = 6'(respCur[l]);
                    calcPre    = 6'(respPre[l]);
                    calcPost   = 6'(respPost[l]);
                    @(posedge clk);
                    #1;
                    calcDone   = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every ack must match the oldest expected grant.
    initial begin
        exp_t             e;
        logic [LANES-1:0] oneHot;
        forever begin
            @(negedge clk);
            if (ack != '0) begin
                ackCount++;
                if (sbq.size() == 0) begin
                    check("unexpected_ack", longint'(ack), 0);
                end else begin
                    e = sbq.pop_front();
                    oneHot = '0;
                    oneHot[e.lane] = 1'b1;
                    check("ack_lane", longint'(ack), longint'(oneHot));
                    check("cursor", longint'(CursorCoff[e.lane*6 +: 6]), e.cur);
                    check("precursor", longint'(PreCursorCoff[e.lane*6 +: 6]), e.pre);
                    check("postcursor", longint'(PostCursorCoff[e.lane*6 +: 6]), e.post);
                    if (e.cycle >= 0) check("ack_cycle", cyc, e.cycle);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic doReset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        enable   = 1'b0;
        reqHold  = '0;
        muteMask = '0;
        numberOfDetectedLanes = 5'd0;
        for (int i = 0; i < LANES; i++) keep[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitAcks(input string name, input int target, input int budget);
        int n = 0;
        while (ackCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, ackCount, target);
    endtask

    task automatic waitStart(input string name, input int target, input int budget);
        int n = 0;
        while (startCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, startCount, target);
    endtask

    initial begin
        int t, s, a0, s0;
        logic seenBusy;
        reset     = 1'b1;
        enable    = 1'b0;
        reqHold   = '0;
        muteMask  = '0;
        respDelay = 2;
        numberOfDetectedLanes = 5'd0;
        for (int i = 0; i < LANES; i++) begin
            keep[i]     = 0;
            respCur[i]  = 0;
            respPre[i]  = 0;
            respPost[i] = 0;
            reqPreset[i*4 +: 4] = 4'(i);
        end

        // Reset state
        doReset();
        check("rst_calcStart", calcStart, 0);
        check("rst_calcLane", calcLane, 0);
        check("rst_calcPreset", calcPreset, 0);
        check("rst_ack", longint'(ack), 0);
        check("rst_busy", busy, 0);
        check("rst_allDone", allDone, 0);
        check("rst_timeoutErr", timeoutErr, 0);
        check("rst_cursor", (CursorCoff != '0), 0);
        check("rst_pre", (PreCursorCoff != '0), 0);
        check("rst_post", (PostCursorCoff != '0), 0);

        // Single lane, preset 5, 3-cycle calculator
        reqPreset[3:0] = 4'd5;
        respDelay  = 3;
        respCur[0] = 40; respPre[0] = 5; respPost[0] = 10;
        t = cyc;
        enable  = 1'b1;
        numberOfDetectedLanes = 5'd4;
        reqHold = 16'h0001;
        sbq.push_back('{0, 40, 5, 10, t + 5});
        waitStart("t1_start_seen", 1, 10);
        check("t1_start_cycle", startCyc, t + 1);
        check("t1_start_lane", startLane, 0);
        check("t1_start_preset", startPreset, 5);
        waitAcks("t1_ack_seen", 1, 20);
        check("t1_alldone_partial", allDone, 0);
        reqHold = '0;

        // All four lanes held, 2-cycle calculator
        doReset();
        respDelay = 2;
        for (int i = 0; i < 4; i++) begin
            respCur[i] = 20 + i; respPre[i] = 1 + 2 * i; respPost[i] = 30 + 3 * i;
        end
        a0 = ackCount;
        s0 = startCount;
        t  = cyc;
        enable  = 1'b1;
        numberOfDetectedLanes = 5'd4;
        reqHold = 16'h000F;
        sbq.push_back('{0, 20, 1, 30, t + 4});
        sbq.push_back('{1, 21, 3, 33, t + 9});
        sbq.push_back('{2, 22, 5, 36, t + 14});
        sbq.push_back('{3, 23, 7, 39, t + 19});
        waitAcks("t2_acks_seen", a0 + 4, 60);
        check("t2_alldone", allDone, 1);
        waitCyc(6);
        check("t2_start_count", startCount - s0, 4);
        check("t2_alldone_hold", allDone, 1);
        reqHold = '0;

        // Requests only on inactive lanes
        doReset();
        s0 = startCount;
        enable  = 1'b1;
        numberOfDetectedLanes = 5'd2;
        reqHold = 16'h000C;
        seenBusy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            waitCyc(1);
            seenBusy = seenBusy | busy;
        end
        check("t3_no_start", startCount - s0, 0);
        check("t3_busy", seenBusy, 0);
        check("t3_alldone", allDone, 0);
        reqHold = '0;

        // Calculator never answers lane 0
        doReset();
        respDelay = 2;
        muteMask  = 16'h0001;
        respCur[1] = 33; respPre[1] = 17; respPost[1] = 9;
        a0 = ackCount;
        s0 = startCount;
        enable  = 1'b1;
        numberOfDetectedLanes = 5'd4;
        reqHold = 16'h0003;
        waitStart("t4_start_seen", s0 + 1, 10);
        s = startCyc;
        check("t4_first_lane", startLane, 0);
        sbq.push_back('{1, 33, 17, 9, s + 69});
        waitUntil(s + 63);
        check("t4_no_err_early", timeoutErr, 0);
        waitUntil(s + 65);
        check("t4_err_set", timeoutErr, 1);
        check("t4_lane0_cursor", longint'(CursorCoff[5:0]), 0);
        check("t4_no_ack", ackCount, a0);
        waitAcks("t4_next_ack", a0 + 1, 20);
        reqHold  = '0;
        muteMask = '0;
        check("t4_err_sticky", timeoutErr, 1);

        // enable dropped in WAIT with calcDone on the same cycle
        doReset();
        respDelay = 2;
        respCur[0] = 11; respPre[0] = 12; respPost[0] = 13;
        t = cyc;
        enable  = 1'b1;
        numberOfDetectedLanes = 5'd2;
        reqHold = 16'h0001;
        sbq.push_back('{0, 11, 12, 13, t + 4});
        a0 = ackCount;
        waitAcks("t5_lane0_ack", a0 + 1, 20);
        reqHold = '0;
        waitCyc(2);
        respDelay = 3;
        respCur[1] = 44; respPre[1] = 45; respPost[1] = 46;
        s0 = startCount;
        a0 = ackCount;
        reqHold = 16'h0002;
        waitStart("t5_start_seen", s0 + 1, 10);
        s = startCyc;
        waitUntil(s + 3);
        enable = 1'b0;
        waitUntil(s + 4);
        check("t5_busy", busy, 0);
        waitCyc(2);
        check("t5_no_ack", ackCount, a0);
        check("t5_lane1_cursor", longint'(CursorCoff[11:6]), 0);
        check("t5_lane1_post", longint'(PostCursorCoff[11:6]), 0);
        check("t5_lane0_kept", longint'(CursorCoff[5:0]), 11);
        reqHold = '0;
        numberOfDetectedLanes = 5'd1;
        waitCyc(1);
        enable = 1'b1;
        waitCyc(2);
        check("t5_donevec_cleared", allDone, 0);
        check("t5_timeout_clear", timeoutErr, 0);

        // Lane 1 holds req one cycle past its ack while lane 2 requests
        doReset();
        respDelay = 2;
        respCur[1] = 7;  respPre[1] = 8;  respPost[1] = 9;
        respCur[2] = 50; respPre[2] = 51; respPost[2] = 52;
        respCur[3] = 60; respPre[3] = 61; respPost[3] = 62;
        keep[1] = 1;
        a0 = ackCount;
        s0 = startCount;
        t  = cyc;
        enable  = 1'b1;
        numberOfDetectedLanes = 5'd4;
        reqHold = 16'h0006;
        sbq.push_back('{1, 7, 8, 9, t + 4});
        sbq.push_back('{2, 50, 51, 52, t + 9});
        waitAcks("t6_acks_seen", a0 + 2, 30);
        waitCyc(4);
        check("t6_start_count", startCount - s0, 2);
        reqHold = '0;
        waitCyc(2);

        // A lone lane holding req past its ack is not re-granted
        keep[3] = 1;
        a0 = ackCount;
        s0 = startCount;
        t  = cyc;
        reqHold = 16'h0008;
        sbq.push_back('{3, 60, 61, 62, t + 4});
        waitAcks("t6_lane3_ack", a0 + 1, 20);
        waitCyc(6);
        check("t6_lane3_single", startCount - s0, 1);
        reqHold = '0;
        waitCyc(2);

        check("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
